conv_stream_ctrl: RTL and testbench

CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

---
 rtl/conv_stream_ctrl.sv | 168 ++++++++++++++++
 tb/tb_conv_stream_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: streams image columns from word-wide memory into a column handshake.
// Ports:
//   clk, rst (async, active-high)  start / abort  frame control pulses
//   mem_rd_en, mem_addr -> memory  mem_rd_data <- memory, MEM_LATENCY cycles later
//   col_valid / col_ready           column handshake; col_data, col_idx, ch_idx,
//                                   win_valid, out_col_num, col_last describe the column
//   busy, done                      frame status
module conv_stream_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int MEM_WIDTH   = 256,
    parameter int NUM_CH      = 1,
    parameter int STRIDE      = 1,
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    output logic                             mem_rd_en,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [MEM_WIDTH-1:0]             mem_rd_data,
    output logic                             col_valid,
    input  logic                             col_ready,
    output logic [IMAGE_SIZE*DATA_WIDTH-1:0] col_data,
    output logic [$clog2(IMAGE_SIZE):0]      col_idx,
    output logic [$clog2(NUM_CH):0]          ch_idx,
    output logic [$clog2(IMAGE_SIZE):0]      out_col_num,
    output logic                             win_valid,
    output logic                             col_last,
    output logic                             busy,
    output logic                             done
);
    localparam int PIX = MEM_WIDTH / DATA_WIDTH;
    localparam int WPC = (IMAGE_SIZE + PIX - 1) / PIX;
    localparam int CW  = $clog2(IMAGE_SIZE) + 1;
    localparam int HW  = $clog2(NUM_CH) + 1;
    localparam int WW  = $clog2(WPC) + 1;

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
    state_t state, state_nx;

    logic [HW-1:0] rd_ch, mv_ch;
    logic [CW-1:0] rd_col, mv_col, num_nx;
    logic [WW-1:0] rd_w;
    logic [WW-1:0] tag_w [MEM_LATENCY];
    logic [MEM_LATENCY-1:0] tag_v, tag_l;
    logic [1:0] open_cnt;
    logic [IMAGE_SIZE*DATA_WIDTH-1:0] asm_buf, asm_nx;
    logic rd_done, asm_full, kill, xfer, move, cap, rd_last_w, rd_last, win_nx, last_nx;
    int mv_d;

    assign kill      = abort && state != IDLE;
    assign xfer      = col_valid && col_ready;
    assign move      = asm_full && (!col_valid || col_ready);
    assign cap       = tag_v[MEM_LATENCY-1];
    assign rd_last_w = rd_w == WW'(WPC - 1);
    assign rd_last   = rd_last_w && rd_col == CW'(IMAGE_SIZE - 1) && rd_ch == HW'(NUM_CH - 1);
    // open_cnt counts columns whose reads have begun but that have not yet transferred;
    // capping it at two keeps column N+2 from starting before column N leaves.
    assign mem_rd_en = state == READ && !rd_done && (rd_w != '0 || open_cnt < 2'd2);
    assign mem_addr  = ADDR_W'((int'(rd_ch) * IMAGE_SIZE + int'(rd_col)) * WPC + int'(rd_w));
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_comb begin
        asm_nx = asm_buf;
        for (int r = 0; r < IMAGE_SIZE; r++)
            if (cap && int'(tag_w[MEM_LATENCY-1]) == r / PIX)
                asm_nx[r*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data[(r % PIX)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        mv_d    = int'(mv_col) - (KERNEL_SIZE - 1);
        win_nx  = mv_d >= 0 && mv_d % STRIDE == 0;
        num_nx  = win_nx ? CW'(mv_d / STRIDE) : '0;
        last_nx = mv_col == CW'(IMAGE_SIZE - 1) && mv_ch == HW'(NUM_CH - 1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? READ : IDLE;
            READ: state_nx = (xfer && col_last) ? DONE : (asm_full && col_valid && !col_ready) ? HOLD : READ;
            HOLD: state_nx = xfer ? READ : HOLD;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_ch       <= '0;
            rd_col      <= '0;
            rd_w        <= '0;
            rd_done     <= 1'b0;
            mv_ch       <= '0;
            mv_col      <= '0;
            open_cnt    <= '0;
            tag_v       <= '0;
            tag_l       <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) tag_w[i] <= '0;
            asm_buf     <= '0;
            asm_full    <= 1'b0;
            col_valid   <= 1'b0;
            col_data    <= '0;
            col_idx     <= '0;
            ch_idx      <= '0;
            out_col_num <= '0;
            win_valid   <= 1'b0;
            col_last    <= 1'b0;
        end else begin
            state    <= state_nx;
            asm_buf  <= asm_nx;
            tag_w[0] <= rd_w;
            tag_l[0] <= rd_last_w;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_w[i] <= tag_w[i-1];
                tag_l[i] <= tag_l[i-1];
            end
            if (kill || state == IDLE) begin
                rd_ch     <= '0;
                rd_col    <= '0;
                rd_w      <= '0;
                rd_done   <= 1'b0;
                mv_ch     <= '0;
                mv_col    <= '0;
                open_cnt  <= '0;
                tag_v     <= '0;
                asm_full  <= 1'b0;
                col_valid <= 1'b0;
            end else begin
                tag_v[0] <= mem_rd_en;
                for (int i = 1; i < MEM_LATENCY; i++) tag_v[i] <= tag_v[i-1];
                if (mem_rd_en) begin
                    rd_done <= rd_last;
                    rd_w    <= rd_last_w ? '0 : rd_w + 1'b1;
                    if (rd_last_w) begin
                        rd_col <= rd_col == CW'(IMAGE_SIZE - 1) ? '0 : rd_col + 1'b1;
                        if (rd_col == CW'(IMAGE_SIZE - 1))
                            rd_ch <= rd_ch == HW'(NUM_CH - 1) ? '0 : rd_ch + 1'b1;
                    end
                end
                open_cnt <= open_cnt + {1'b0, mem_rd_en && rd_w == '0} - {1'b0, xfer};
                // A freshly completed column wins over clearing the one just moved out.
                asm_full <= (cap && tag_l[MEM_LATENCY-1]) || (asm_full && !move);
                if (move) begin
                    col_valid   <= 1'b1;
                    col_data    <= asm_buf;
                    col_idx     <= mv_col;
                    ch_idx      <= mv_ch;
                    win_valid   <= win_nx;
                    out_col_num <= num_nx;
                    col_last    <= last_nx;
                    mv_col      <= mv_col == CW'(IMAGE_SIZE - 1) ? '0 : mv_col + 1'b1;
                    if (mv_col == CW'(IMAGE_SIZE - 1))
                        mv_ch <= mv_ch == HW'(NUM_CH - 1) ? '0 : mv_ch + 1'b1;
                end else if (xfer) begin
                    col_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb_conv_stream_ctrl: randomized column-stream bench against a behavioural frame model.
module tb_conv_stream_ctrl;
    localparam int DW = 16, KS = 5, IS = 28, MW = 256, NCH = 2, STR = 2, LAT = 3, AW = 12;
    localparam int PIX = MW / DW, WPC = (IS + PIX - 1) / PIX, NCOL = NCH * IS;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, col_ready = 1'b0;
    logic mem_rd_en, col_valid, win_valid, col_last, busy, done;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_rd_data, garbage;
    logic [IS*DW-1:0] col_data;
    logic [$clog2(IS):0] col_idx, out_col_num;
    logic [$clog2(NCH):0] ch_idx;
    logic pv [LAT] = '{default: 1'b0};
    logic [AW-1:0] pa [LAT];
    logic [511:0] snap;
    int checks = 0, failures = 0, exp_addr = 0, xfers = 0, dones = 0, mode = 0, stall = 0, mark;
    bit hold_prev = 0;

    always #5 clk = ~clk;

    conv_stream_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .IMAGE_SIZE(IS), .MEM_WIDTH(MW),
                       .NUM_CH(NCH), .STRIDE(STR), .MEM_LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .col_valid(col_valid),
        .col_ready(col_ready), .col_data(col_data), .col_idx(col_idx), .ch_idx(ch_idx),
        .out_col_num(out_col_num), .win_valid(win_valid), .col_last(col_last),
        .busy(busy), .done(done));

    function automatic logic [DW-1:0] pix(int a, int l);
        return DW'(a * 40503 + l * 7919 + 3);
    endfunction

    function automatic logic [MW-1:0] word(int a);
        logic [MW-1:0] v;
        for (int l = 0; l < PIX; l++) v[l*DW +: DW] = pix(a, l);
        return v;
    endfunction

    // Column n of the frame (channel-major) reassembled from the memory image.
    function automatic logic [IS*DW-1:0] col_exp(int n);
        logic [IS*DW-1:0] v;
        for (int r = 0; r < IS; r++) v[r*DW +: DW] = pix(n * WPC + r / PIX, r % PIX);
        return v;
    endfunction

    function automatic logic [511:0] cur();
        return 512'({col_data, col_idx, ch_idx, out_col_num, win_valid, col_last});
    endfunction

    // Memory returns the addressed word exactly LAT cycles after the strobe, noise otherwise.
    always @(posedge clk) begin
        garbage <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pv[0] <= mem_rd_en;
        pa[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_rd_data = pv[LAT-1] ? word(int'(pa[LAT-1])) : garbage;

    task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_valid", col_valid, 1);
            chk("hold_stable", cur(), snap);
        end
        if (mem_rd_en) begin
            chk("rd_addr", mem_addr, exp_addr);
            chk("rd_gate", exp_addr / WPC <= xfers + 1, 1);
            exp_addr++;
        end
        if (col_valid && col_ready) begin
            int c = xfers % IS;
            int d = c - (KS - 1);
            bit w = d >= 0 && d % STR == 0;
            chk("extra_col", xfers < NCOL, 1);
            chk("col_data", col_data, col_exp(xfers));
            chk("col_idx", col_idx, c);
            chk("ch_idx", ch_idx, xfers / IS);
            chk("win_valid", win_valid, w);
            chk("out_col_num", out_col_num, w ? d / STR : 0);
            chk("col_last", col_last, xfers == NCOL - 1);
            xfers++;
        end
        if (done) dones++;
        hold_prev = col_valid && !col_ready && !abort && !rst;
        snap = cur();
        @(posedge clk);
        #1;
        if (mode == 2) begin
            col_ready = 1'b1;
            if (col_valid && xfers == 3 && stall < 10) begin
                col_ready = 1'b0;
                stall++;
                if (stall == 10) chk("stall_reads", exp_addr, 5 * WPC);
            end
        end else begin
            col_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic begin_frame(int m);
        mode = m;
        stall = 0;
        exp_addr = 0;
        xfers = 0;
        dones = 0;
        hold_prev = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(int m, bit poke);
        begin_frame(m);
        for (int i = 0; i < 4000 && dones == 0; i++) begin
            start = poke && xfers == 20;
            tick();
        end
        start = 1'b0;
        repeat (4) tick();
        chk("frame_cols", xfers, NCOL);
        chk("frame_reads", exp_addr, NCOL * WPC);
        chk("done_pulses", dones, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", col_valid, 0);
        chk("rst_status", {busy, done}, 0);
        chk("rst_meta", {col_idx, ch_idx, out_col_num, win_valid, col_last}, 0);
        chk("rst_data", col_data, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_noread", exp_addr, 0);

        run_frame(0, 0);
        run_frame(1, 1);
        run_frame(2, 0);
        run_frame(3, 0);

        begin_frame(1);
        for (int i = 0; i < 2000 && xfers < 10; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", col_valid, 0);
        chk("abort_busy", busy, 0);
        mark = exp_addr;
        repeat (6) tick();
        chk("abort_noread", exp_addr, mark);
        chk("abort_nodone", dones, 0);
        run_frame(1, 0);

        begin_frame(0);
        for (int i = 0; i < 2000 && !(xfers >= 5 && col_valid); i++) tick();
        rst = 1'b1;
        #2;
        chk("mid_rst_ctrl", {mem_rd_en, mem_addr, col_valid, busy, done}, 0);
        chk("mid_rst_meta", {col_idx, ch_idx, out_col_num, win_valid, col_last}, 0);
        chk("mid_rst_data", col_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hold_prev = 0;
        exp_addr = 0;
        dones = 0;
        repeat (5) tick();
        chk("rst_noread", exp_addr, 0);
        chk("rst_nodone", dones, 0);
        run_frame(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
